// File: rtl/lcd_bus_writer_if.sv
// Beat handshake between the data-transfer stage and the LCD bus writer.
// Carries {rs, word} with a valid/ready pair.
interface lcd_bus_writer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_rs;
    logic [DATA_WIDTH-1:0] in_data;

    modport master (
        output in_valid,
        output in_rs,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_rs,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/lcd_bus_writer.sv
// 8080-style LCD parallel write bus driver with a small input FIFO.
// Programmable strobe widths; chip-select held between back-to-back beats.
module lcd_bus_writer #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int IDLE_CYC   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    lcd_bus_writer_if.slave       s_in,
    input  logic [3:0]            wr_low_cyc,
    input  logic [3:0]            wr_high_cyc,
    output logic                  lcd_cs_n,
    output logic                  lcd_rs,
    output logic                  lcd_wr_n,
    output logic                  lcd_rd_n,
    output logic [DATA_WIDTH-1:0] lcd_data,
    output logic                  busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(IDLE_CYC + 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, WR_LOW, WR_HIGH, HOLD
    } state_t;

    state_t r_state;
    state_t w_nstate;

    logic [DATA_WIDTH:0] r_mem [FIFO_DEPTH];
    logic [AW:0]         r_wptr;
    logic [AW:0]         r_rptr;
    logic [3:0]          r_cnt;
    logic [3:0]          r_hcyc;
    logic [IW-1:0]       r_idle;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_cs_n;
    logic                w_wr_n;
    logic [3:0]          w_l;
    logic [3:0]          w_h;
    logic [DATA_WIDTH:0] w_head;

    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty = (r_wptr == r_rptr);
    assign w_head  = r_mem[r_rptr[AW-1:0]];

    assign s_in.in_ready = !w_full && !rst;
    assign w_push        = s_in.in_valid && s_in.in_ready;

    assign w_l = (wr_low_cyc  == 4'd0) ? 4'd1 : wr_low_cyc;
    assign w_h = (wr_high_cyc == 4'd0) ? 4'd1 : wr_high_cyc;

    assign lcd_rd_n = 1'b1;
    assign busy     = !w_empty || (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nstate;
        end
    end

    always_comb begin
        w_nstate = r_state;
        case (r_state)
            IDLE: begin
                if (!w_empty) w_nstate = SETUP;
            end
            SETUP: begin
                w_nstate = WR_LOW;
            end
            WR_LOW: begin
                if (r_cnt == 4'd0) w_nstate = WR_HIGH;
            end
            WR_HIGH: begin
                if (r_cnt == 4'd0) w_nstate = w_empty ? HOLD : SETUP;
            end
            HOLD: begin
                if (!w_empty)
                    w_nstate = SETUP;
                else if (r_idle == IW'(IDLE_CYC - 1))
                    w_nstate = IDLE;
            end
            default: w_nstate = IDLE;
        endcase
    end

    // Registered bus outputs follow the state being entered.
    always_comb begin
        w_cs_n = (w_nstate == IDLE);
        w_wr_n = (w_nstate != WR_LOW);
        w_pop  = (w_nstate == SETUP);
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= {s_in.in_rs, s_in.in_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            lcd_cs_n <= 1'b1;
            lcd_wr_n <= 1'b1;
            lcd_rs   <= 1'b0;
            lcd_data <= '0;
            r_cnt    <= '0;
            r_hcyc   <= 4'd1;
            r_idle   <= '0;
        end else begin
            lcd_cs_n <= w_cs_n;
            lcd_wr_n <= w_wr_n;
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop) begin
                r_rptr             <= r_rptr + (AW+1)'(1);
                {lcd_rs, lcd_data} <= w_head;
            end
            // Widths are captured once per beat, leaving SETUP.
            case (r_state)
                SETUP: begin
                    r_cnt  <= w_l - 4'd1;
                    r_hcyc <= w_h;
                end
                WR_LOW: begin
                    r_cnt <= (r_cnt == 4'd0) ? r_hcyc - 4'd1
                                             : r_cnt - 4'd1;
                end
                WR_HIGH: begin
                    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                end
                default: r_cnt <= r_cnt;
            endcase
            if (r_state == HOLD) r_idle <= r_idle + IW'(1);
            else                 r_idle <= '0;
        end
    end
endmodule

// File: tb/tb_lcd_bus_writer.sv
// Bench for lcd_bus_writer: directed timing cases plus random beats
// scored against a queue of expected beats and strobe widths.
module tb_lcd_bus_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  wr_low_cyc = 4'd1;
    logic [3:0]  wr_high_cyc = 4'd1;
    logic        lcd_cs_n;
    logic        lcd_rs;
    logic        lcd_wr_n;
    logic        lcd_rd_n;
    logic [15:0] lcd_data;
    logic        busy;

    lcd_bus_writer_if #(.DATA_WIDTH(16)) bus ();

    lcd_bus_writer #(
        .DATA_WIDTH(16),
        .FIFO_DEPTH(4),
        .IDLE_CYC(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_in(bus),
        .wr_low_cyc(wr_low_cyc),
        .wr_high_cyc(wr_high_cyc),
        .lcd_cs_n(lcd_cs_n),
        .lcd_rs(lcd_rs),
        .lcd_wr_n(lcd_wr_n),
        .lcd_rd_n(lcd_rd_n),
        .lcd_data(lcd_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] bus;
        int          lw;
    } beat_t;

    beat_t exp_q[$];
    int    rise_q[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    cs_rise = 0;
    int    n_beats = 0;
    int    n_acc = 0;
    int    blk_at = 0;
    bit    blk_seen = 0;
    bit    quiet = 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Bus observer: every cycle, sampled on the falling edge.
    logic        p_wr = 1'b1;
    logic        p_cs = 1'b1;
    logic [16:0] p_bus = '0;
    int          low_start = 0;
    always @(negedge clk) begin
        beat_t e;
        chk("rd_n", {31'd0, lcd_rd_n}, 32'd1);
        if (!quiet) begin
            if (!lcd_wr_n) chk("cs_during_wr", {31'd0, lcd_cs_n}, 32'd0);
            if (!p_wr) chk("data_hold", {15'd0, lcd_rs, lcd_data}, {15'd0, p_bus});
            if (!lcd_wr_n && p_wr) low_start = cyc;
            if (lcd_wr_n && !p_wr) begin
                rise_q.push_back(cyc);
                n_beats++;
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", {15'd0, lcd_rs, lcd_data}, {15'd0, e.bus});
                    chk("low_width", cyc - low_start, e.lw);
                end
            end
            if (lcd_cs_n && !p_cs) cs_rise++;
        end
        p_wr  = lcd_wr_n;
        p_cs  = lcd_cs_n;
        p_bus = {lcd_rs, lcd_data};
    end

    task automatic push(input logic rs, input logic [15:0] d,
                        input int lw, output int acc);
        int n;
        bus.in_valid = 1'b1;
        bus.in_rs    = rs;
        bus.in_data  = d;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            if (!blk_seen) begin
                blk_seen = 1;
                blk_at   = n_acc;
            end
            n++;
            @(negedge clk);
        end
        if (n >= 200) chk("push_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        acc = cyc;
        n_acc++;
        exp_q.push_back('{bus: {rs, d}, lw: lw});
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // sel: 0 = cs_n, 1 = wr_n, 2 = busy
    task automatic wait_for(input int sel, input logic v, output int c);
        int   n;
        logic s;
        s = 1'b0;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            s = (sel == 0) ? lcd_cs_n : (sel == 1) ? lcd_wr_n : busy;
            if (s == v) break;
        end
        if (n >= 300) chk("wait_timeout", 32'd1, 32'd0);
        c = cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k2, c, cr, nb, l, h, lw;
        bus.in_valid = 1'b0;
        bus.in_rs    = 1'b0;
        bus.in_data  = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", {31'd0, lcd_cs_n}, 32'd1);
        chk("rst_wr_n", {31'd0, lcd_wr_n}, 32'd1);
        chk("rst_rs", {31'd0, lcd_rs}, 32'd0);
        chk("rst_data", {16'd0, lcd_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        quiet = 0;

        // single beat, 12 cycles from accept to cs_n release
        wr_low_cyc  = 4'd1;
        wr_high_cyc = 4'd1;
        push(1'b0, 16'h002A, 1, k);
        idle(0);
        wait_for(0, 1'b0, c);
        chk("t1_cs_fall", c - k, 32'd1);
        wait_for(1, 1'b0, c);
        chk("t1_wr_fall", c - k, 32'd2);
        wait_for(1, 1'b1, c);
        chk("t1_wr_rise", c - k, 32'd3);
        wait_for(0, 1'b1, c);
        chk("t1_cs_rise", c - k, 32'd12);
        chk("t1_busy", {31'd0, busy}, 32'd0);

        // burst of 6 with valid held, L=3 H=2
        wr_low_cyc  = 4'd3;
        wr_high_cyc = 4'd2;
        blk_seen = 0;
        n_acc    = 0;
        cr       = cs_rise;
        rise_q.delete();
        for (int i = 1; i <= 6; i++) push(1'b1, 16'(i), 3, k);
        idle(0);
        wait_for(2, 1'b0, c);
        chk("t2_blocked", {31'd0, blk_seen}, 32'd1);
        chk("t2_block_at", blk_at, 32'd5);
        chk("t2_nbeats", rise_q.size(), 32'd6);
        for (int i = 1; i < rise_q.size(); i++)
            chk("t2_gap", rise_q[i] - rise_q[i-1], 32'd6);
        chk("t2_cs_rises", cs_rise - cr, 32'd1);

        // zero widths behave as 1/1
        wr_low_cyc  = 4'd0;
        wr_high_cyc = 4'd0;
        rise_q.delete();
        for (int i = 0; i < 3; i++) push(1'b0, 16'hA500 + 16'(i), 1, k);
        idle(0);
        wait_for(2, 1'b0, c);
        chk("t3_nbeats", rise_q.size(), 32'd3);
        for (int i = 1; i < rise_q.size(); i++)
            chk("t3_gap", rise_q[i] - rise_q[i-1], 32'd3);

        // width change during WR_LOW only affects the queued beat
        wr_low_cyc  = 4'd2;
        wr_high_cyc = 4'd1;
        push(1'b1, 16'h1111, 2, k);
        push(1'b0, 16'h2222, 7, k);
        idle(0);
        wait_for(1, 1'b0, c);
        wr_low_cyc = 4'd7;
        wait_for(2, 1'b0, c);

        // beat in the last HOLD cycle -> no cs_n pulse
        wr_low_cyc  = 4'd1;
        wr_high_cyc = 4'd1;
        rise_q.delete();
        cr = cs_rise;
        push(1'b0, 16'h0055, 1, k);
        idle(10);
        push(1'b1, 16'h0066, 1, k2);
        idle(0);
        chk("t5_accept", k2 - k, 32'd11);
        wait_for(2, 1'b0, c);
        chk("t5_cs_rises", cs_rise - cr, 32'd1);
        chk("t5_gap", rise_q[1] - rise_q[0], 32'd11);

        // one cycle later: cs_n must release first
        cr = cs_rise;
        push(1'b0, 16'h0077, 1, k);
        idle(11);
        push(1'b1, 16'h0088, 1, k2);
        idle(0);
        chk("t5b_accept", k2 - k, 32'd12);
        wait_for(2, 1'b0, c);
        chk("t5b_cs_rises", cs_rise - cr, 32'd2);

        // reset during WR_LOW with 3 entries queued
        wr_low_cyc = 4'd5;
        for (int i = 0; i < 4; i++) push(1'b1, 16'hC000 + 16'(i), 5, k);
        idle(0);
        wait_for(1, 1'b0, c);
        quiet = 1;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_cs_n", {31'd0, lcd_cs_n}, 32'd1);
        chk("t6_wr_n", {31'd0, lcd_wr_n}, 32'd1);
        chk("t6_data", {16'd0, lcd_data}, 32'd0);
        chk("t6_rs", {31'd0, lcd_rs}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_ready", {31'd0, bus.in_ready}, 32'd0);
        exp_q.delete();
        nb  = n_beats;
        rst = 1'b0;
        @(posedge clk);
        #1;
        quiet = 0;
        idle(30);
        chk("t6_no_stale", n_beats - nb, 32'd0);
        chk("t6_idle_busy", {31'd0, busy}, 32'd0);
        chk("t6_ready_back", {31'd0, bus.in_ready}, 32'd1);

        // random segments: constant widths per segment, random gaps
        for (int s = 0; s < 5; s++) begin
            l  = $urandom_range(0, 5);
            h  = $urandom_range(0, 5);
            lw = (l == 0) ? 1 : l;
            wr_low_cyc  = 4'(l);
            wr_high_cyc = 4'(h);
            for (int j = 0; j < 10; j++) begin
                push(1'($urandom_range(0, 1)), 16'($urandom), lw, k);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 12));
            end
            idle(0);
            wait_for(2, 1'b0, c);
            chk("rand_drain", exp_q.size(), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
